// File: rtl/hif_fir_sequencer.sv
// hif_fir_sequencer: coefficient-ROM address sequencer and MAC for the HF sample queue.
// Define FIR_SAT_EN to saturate the scaled output instead of wrapping it.
module hif_fir_sequencer #(
  parameter int NUM_TAPS = 1021,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sequencing,
  input  logic [15:0]       smpl_in,
  input  logic [15:0]       coeff,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic [15:0]       smpl_out,
  output logic              smpl_vld
);
  localparam int ACC_W = 42;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  TAPS_C = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        tap_cnt;
  logic                    accept;
  logic                    vld_p0;
  logic signed [31:0]      prod_p0;
  logic signed [ACC_W-1:0] acc_p1, acc_d;

  // Drop the Q1.15 coefficient gain; optionally clamp when the sum leaves 16 bits.
  function automatic logic [15:0] scale(input logic signed [ACC_W-1:0] a);
    logic [15:0] r;
    r = a[30:15];
`ifdef FIR_SAT_EN
    if (a[ACC_W-1:30] != {(ACC_W-30){a[ACC_W-1]}})
      r = a[ACC_W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sequencing) state_d = ACCUM;
      ACCUM:   if (!sequencing) state_d = DRAIN;
      DRAIN:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Taps beyond NUM_TAPS are neither addressed nor accumulated.
  always_comb begin
    accept  = sequencing && (state_q == IDLE || state_q == ACCUM) && (tap_cnt < TAPS_C);
    prod_p0 = $signed({{16{smpl_in[15]}}, smpl_in}) * $signed({{16{coeff[15]}}, coeff});
    acc_d   = acc_p1;
    if (state_q == IDLE)
      acc_d = '0;
    else if (vld_p0)
      acc_d = acc_p1 + {{(ACC_W-32){prod_p0[31]}}, prod_p0};
  end

  // p0: address issue / data return; p1: accumulate; output registered on DRAIN exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt    <= '0;
      coeff_addr <= '0;
      vld_p0     <= 1'b0;
      acc_p1     <= '0;
      smpl_out   <= '0;
      smpl_vld   <= 1'b0;
    end else begin
      vld_p0   <= accept;
      acc_p1   <= acc_d;
      smpl_vld <= (state_q == DRAIN);
      if (state_q == DRAIN)
        smpl_out <= scale(acc_d);
      if (state_q == OUT) begin
        tap_cnt    <= '0;
        coeff_addr <= '0;
      end else if (accept) begin
        tap_cnt    <= tap_cnt + 1'b1;
        coeff_addr <= (tap_cnt < LAST_C) ? tap_cnt[ADDR_W-1:0] + 1'b1 : LAST_A;
      end
    end
  end
endmodule
